// File: rtl/ldst_unit.sv
// Load/store unit: one word or byte access on a synchronous memory bus with a
// ready handshake, zero-extended load data, and error reporting.
module ldst_unit #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic        byte_s,
  input  logic [31:0] addr,
  input  logic [31:0] w_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] r_data,
  output logic [1:0]  err,
  output logic        mem_en,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_ALIGN = 2'b01;
  localparam logic [1:0] ERR_BUS   = 2'b10;
  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  lane_q, lane_d;
  logic        we_q, we_d;
  logic        byte_q, byte_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [1:0]  err_q, err_d;
  logic [31:0] r_data_q, r_data_d;
  logic        mem_en_q, mem_en_d;
  logic        mem_we_q, mem_we_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [7:0]  rd_byte;

  always_comb begin
    case (lane_q)
      2'd0:    rd_byte = mem_rdata[7:0];
      2'd1:    rd_byte = mem_rdata[15:8];
      2'd2:    rd_byte = mem_rdata[23:16];
      default: rd_byte = mem_rdata[31:24];
    endcase
  end

  always_comb begin
    // NOTE: every _d gets a default first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    cnt_d       = cnt_q;
    lane_d      = lane_q;
    we_d        = we_q;
    byte_d      = byte_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = err_q;
    r_data_d    = r_data_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    unique case (state_q)
      IDLE: begin
        if (req) begin
          lane_d      = addr[1:0];
          we_d        = we;
          byte_d      = byte_s;
          mem_addr_d  = {addr[31:2], 2'b00};
          mem_wdata_d = byte_s ? {4{w_data[7:0]}} : w_data;
          busy_d      = 1'b1;
          if (!byte_s && addr[1:0] != 2'b00) begin
            state_d = DONE;
            done_d  = 1'b1;
            err_d   = ERR_ALIGN;
          end else begin
            state_d  = ACCESS;
            cnt_d    = '0;
            mem_en_d = 1'b1;
            mem_we_d = we;
            mem_be_d = byte_s ? (4'b0001 << addr[1:0]) : 4'hF;
          end
        end
      end
      ACCESS: begin
        // Ready wins over the timeout on the same edge.
        if (mem_ready) begin
          state_d  = DONE;
          done_d   = 1'b1;
          err_d    = ERR_OK;
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
          mem_be_d = 4'h0;
          if (!we_q) r_data_d = byte_q ? {24'b0, rd_byte} : mem_rdata;
        end else if (cnt_q + 8'd1 == TIMEOUT_C) begin
          state_d  = DONE;
          done_d   = 1'b1;
          err_d    = ERR_BUS;
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
          mem_be_d = 4'h0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      lane_q      <= '0;
      we_q        <= 1'b0;
      byte_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= '0;
      r_data_q    <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lane_q      <= lane_d;
      we_q        <= we_d;
      byte_q      <= byte_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      r_data_q    <= r_data_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign r_data    = r_data_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: doc/ldst_unit.md
# ldst_unit

Load/store unit that sits directly downstream of the CPU datapath's ALU result register F. It takes a byte address, store data and an access request from the controller. It performs one word or byte access on a single-port synchronous memory bus with a ready handshake, and returns zero-extended load data plus a one-cycle completion pulse. Unaligned word accesses and unresponsive memory are reported as errors and have no memory side effects.

## Interface
Parameters:
- TIMEOUT, 15: maximum number of ACCESS cycles without `mem_ready` before a bus error; legal range 1..255.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  1  start access; sampled only in IDLE.
- we  in  1  1 = store, 0 = load.
- byte_s  in  1  1 = byte access, 0 = word access.
- addr  in  32  byte address, normally the F register value.
- w_data  in  32  store data, normally the B register value.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- r_data  out  32  last successful load result; held otherwise.
- err  out  2  valid with `done`: 00 ok, 01 unaligned word, 10 bus timeout.
- mem_en  out  1  memory request; high only in ACCESS.
- mem_we  out  1  memory write enable; high only in ACCESS when the latched `we` = 1.
- mem_be  out  4  byte enables.
- mem_addr  out  32  word-aligned address: latched addr with [1:0] forced to 00.
- mem_wdata  out  32  write data.
- mem_rdata  in  32  read data; valid in the cycle `mem_ready` = 1.
- mem_ready  in  1  memory completes the access this cycle.

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE with `req` = 1:
  - Latch addr, we, byte_s and w_data.
  - If word access and addr[1:0] ≠ 00: go to DONE with err = 01. No memory cycle.
  - Otherwise: go to ACCESS and clear the wait counter.
- `req` while busy: ignored. It is not queued.
- ACCESS:
  - `mem_en` = 1.
  - `mem_we` = latched `we`.
  - `mem_be`: word → 4'hF; byte → 4'b0001 << addr[1:0].
  - `mem_wdata`: word → w_data; byte → w_data[7:0] replicated to all four lanes.
  - `mem_ready` = 1: go to DONE with err = 00.
    - Load, word: r_data ← mem_rdata.
    - Load, byte: r_data ← {24'b0, selected byte lane}. Little-endian: lane 0 = bits [7:0].
  - `mem_ready` = 0: the wait counter increments. When the counter equals TIMEOUT, go to DONE with err = 10. r_data is unchanged.
- DONE: `done` = 1 for exactly one cycle, then return to IDLE. `err` holds the code decided on entry.
- r_data changes only on a successful load. Stores and errors never alter it.
- Outside ACCESS: `mem_en`, `mem_we` and `mem_be` are 0. `mem_addr` and `mem_wdata` hold the latched values.

## Timing
- Reset (async): state IDLE, and every output = 0. That covers busy, done, err, r_data, mem_en, mem_we, mem_be, mem_addr and mem_wdata; the wait counter also clears. `mem_en` deasserts immediately when `rst` rises, including mid-ACCESS. An aborted access produces no `done`.
- `req` sampled at edge 0 → ACCESS after edge 0. `mem_ready` = 1 at edge 1 → `done` high between edge 1 and edge 2. Minimum req-to-done latency is 2 cycles.
- Each wait state adds 1 cycle. Timeout with no ready: `done` asserts TIMEOUT + 1 cycles after the req edge. A `mem_ready` on the same edge where the counter reaches TIMEOUT counts as success.
- Unaligned word: `done` with err = 01 in the cycle after the req edge (1-cycle latency).
- Back-to-back: a new `req` is accepted in the IDLE cycle following DONE. Minimum request spacing is 3 cycles.
- `done`, `err` and `r_data` are stable for the full DONE cycle. The CPU captures the result on its negedge within that cycle.
- Byte access ignores alignment. Any addr[1:0] is legal.

## Test plan
- Reset, then word store with addr = 0x10, w_data = 0xDEADBEEF, zero wait.
  - Required: mem_addr = 0x10, mem_be = F, mem_we = 1 for one cycle; done 2 cycles after req; err = 00; r_data = 0.
- Word load at 0x10 with mem_rdata = 0xDEADBEEF and 3 wait states.
  - Required: mem_en held for 4 cycles; done 5 cycles after req; r_data = 0xDEADBEEF.
- Byte load at 0x12 with mem_rdata = 0xDEADBEEF → mem_be = 0100, r_data = 0x000000AD.
- Byte store at 0x13 with w_data = 0x12345677 → mem_be = 1000, mem_wdata = 0x77777777.
- Word load at 0x06.
  - Required: no mem_en; done the next cycle; err = 01; r_data keeps its previous value.
- mem_ready tied low with TIMEOUT = 15.
  - Required: done with err = 10 16 cycles after req; then raise `req` mid-ACCESS of a fresh access and assert `rst`: mem_en drops asynchronously, no done, all outputs 0.
